seg_scan_ctrl: RTL

//  Time-multiplexed scan controller for an NDIG-digit common-anode 7-segment bank.
//  - Holds a shadow copy of the hex digits, decimal points and enable mask.
//  - Cycles one digit at a time, with a blanking gap between digits.
//  - Accepts new display data only at frame end, so a frame never shows mixed old/new data.
//  - Sits between the CPU/MMIO display register and the board segment/anode pins.

---
 rtl/seg_scan_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan controller for an NDIG-digit common-anode 7-segment
// bank. A shadow copy of the digits, decimal points and enable mask is kept
// and only reloaded at frame end (or while idle), so a frame never mixes old
// and new data. Each digit is lit for SCAN_DIV cycles and is followed by
// GAP_CYC all-blank cycles to suppress ghosting. Masked digits keep their
// time slot, so the frame length is fixed.
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 1000,
  parameter int GAP_CYC  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [4*NDIG-1:0] wr_data,
  input  logic [NDIG-1:0]   wr_dp,
  input  logic [NDIG-1:0]   wr_mask,
  output logic [7:0]        seg_n,
  output logic [NDIG-1:0]   an_n,
  output logic              frame_tick
);

  // Counter must hold the longest of the lit and gap phases.
  localparam int CNT_MAX = (SCAN_DIV > GAP_CYC) ? ((SCAN_DIV > 2) ? SCAN_DIV : 2)
                                                : ((GAP_CYC > 2) ? GAP_CYC : 2);
  localparam int CW = $clog2(CNT_MAX);
  localparam int DW = $clog2(NDIG);

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
  localparam logic [DW-1:0] D_LAST    = DW'(NDIG - 1);

  // Segment font, bit7..0 = a,b,c,d,e,f,g,dp (active-high).
  function automatic logic [7:0] font(input logic [3:0] nib);
    logic [7:0] f;
    case (nib)
      4'h0:    f = 8'hFC;
      4'h1:    f = 8'h60;
      4'h2:    f = 8'hDA;
      4'h3:    f = 8'hF2;
      4'h4:    f = 8'h66;
      4'h5:    f = 8'hB6;
      4'h6:    f = 8'hBE;
      4'h7:    f = 8'hE0;
      4'h8:    f = 8'hFE;
      4'h9:    f = 8'hF6;
      4'hA:    f = 8'hEE;
      4'hB:    f = 8'h3E;
      4'hC:    f = 8'h9C;
      4'hD:    f = 8'h7A;
      4'hE:    f = 8'h9E;
      4'hF:    f = 8'h8E;
      default: f = 8'h00;
    endcase
    return f;
  endfunction

  // Registers
  logic [1:0]        r_state;
  logic [DW-1:0]     r_d;
  logic [CW-1:0]     r_cnt;
  logic [4*NDIG-1:0] r_data;
  logic [NDIG-1:0]   r_dp;
  logic [NDIG-1:0]   r_mask;
  logic [7:0]        r_seg_n;
  logic [NDIG-1:0]   r_an_n;
  logic              r_frame_tick;

  // Combinational next values
  logic              w_xfer;
  logic [1:0]        w_state_nx;
  logic [DW-1:0]     w_d_nx;
  logic [CW-1:0]     w_cnt_nx;
  logic [DW-1:0]     w_d_inc;
  logic [4*NDIG-1:0] w_data_nx;
  logic [NDIG-1:0]   w_dp_nx;
  logic [NDIG-1:0]   w_mask_nx;
  logic [3:0]        w_nib;
  logic [7:0]        w_font;
  logic [7:0]        w_seg_nx;
  logic [NDIG-1:0]   w_an_nx;
  logic              w_tick_nx;

  // Data may be taken while idle or on the final cycle of a frame.
  assign wr_ready = rst_n & ((r_state == ST_OFF) | r_frame_tick);
  assign w_xfer   = wr_valid & wr_ready;

  // Shadow contents as they will be after this edge, so a frame-end load
  // is visible on digit 0 with no extra cycle of lag.
  assign w_data_nx = w_xfer ? wr_data : r_data;
  assign w_dp_nx   = w_xfer ? wr_dp   : r_dp;
  assign w_mask_nx = w_xfer ? wr_mask : r_mask;

  assign w_d_inc = (r_d == D_LAST) ? {DW{1'b0}} : (r_d + DW'(1));

  // Scan sequencer: next state, digit index and phase counter.
  always_comb begin
    w_state_nx = r_state;
    w_d_nx     = r_d;
    w_cnt_nx   = r_cnt;
    case (r_state)
      ST_OFF: begin
        w_d_nx   = {DW{1'b0}};
        w_cnt_nx = {CW{1'b0}};
        if (en) begin
          w_state_nx = ST_SCAN;
        end else begin
          w_state_nx = ST_OFF;
        end
      end
      ST_SCAN: begin
        if (!en) begin
          w_state_nx = ST_OFF;
          w_d_nx     = {DW{1'b0}};
          w_cnt_nx   = {CW{1'b0}};
        end else if (r_cnt == SCAN_LAST) begin
          w_cnt_nx = {CW{1'b0}};
          if (GAP_CYC > 0) begin
            w_state_nx = ST_GAP;
          end else begin
            w_state_nx = ST_SCAN;
            w_d_nx     = w_d_inc;
          end
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      ST_GAP: begin
        if (!en) begin
          w_state_nx = ST_OFF;
          w_d_nx     = {DW{1'b0}};
          w_cnt_nx   = {CW{1'b0}};
        end else if (r_cnt == GAP_LAST) begin
          w_state_nx = ST_SCAN;
          w_d_nx     = w_d_inc;
          w_cnt_nx   = {CW{1'b0}};
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nx = ST_OFF;
        w_d_nx     = {DW{1'b0}};
        w_cnt_nx   = {CW{1'b0}};
      end
    endcase
  end

  // Frame tick marks the last cycle of the final digit's slot.
  always_comb begin
    w_tick_nx = 1'b0;
    if (GAP_CYC > 0) begin
      w_tick_nx = (w_state_nx == ST_GAP) && (w_d_nx == D_LAST) && (w_cnt_nx == GAP_LAST);
    end else begin
      w_tick_nx = (w_state_nx == ST_SCAN) && (w_d_nx == D_LAST) && (w_cnt_nx == SCAN_LAST);
    end
  end

  assign w_nib  = w_data_nx[{w_d_nx, 2'b00} +: 4];
  assign w_font = font(w_nib);

  // Pin values for the upcoming cycle: only the active, enabled digit drives.
  always_comb begin
    w_seg_nx = 8'hFF;
    w_an_nx  = {NDIG{1'b1}};
    if (w_state_nx == ST_SCAN) begin
      w_an_nx[w_d_nx] = ~w_mask_nx[w_d_nx];
      if (w_mask_nx[w_d_nx]) begin
        w_seg_nx = ~{w_font[7:1], w_dp_nx[w_d_nx]};
      end else begin
        w_seg_nx = 8'hFF;
      end
    end else begin
      w_seg_nx = 8'hFF;
    end
  end

  // State, shadow data and registered pin drivers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_OFF;
      r_d          <= {DW{1'b0}};
      r_cnt        <= {CW{1'b0}};
      r_data       <= {(4*NDIG){1'b0}};
      r_dp         <= {NDIG{1'b0}};
      r_mask       <= {NDIG{1'b0}};
      r_seg_n      <= 8'hFF;
      r_an_n       <= {NDIG{1'b1}};
      r_frame_tick <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_d          <= w_d_nx;
      r_cnt        <= w_cnt_nx;
      r_data       <= w_data_nx;
      r_dp         <= w_dp_nx;
      r_mask       <= w_mask_nx;
      r_seg_n      <= w_seg_nx;
      r_an_n       <= w_an_nx;
      r_frame_tick <= w_tick_nx;
    end
  end

  assign seg_n      = r_seg_n;
  assign an_n       = r_an_n;
  assign frame_tick = r_frame_tick;

endmodule
